// File: rtl/sequencer_pkg.sv
// sequencer_pkg: shared state type, AXI response codes and register map for the sequencer AXI-Lite arbiter.
package sequencer_pkg;
  typedef enum logic [2:0] {IDLE, WR, WR_B, RD_AR, RD_R, RESP} seq_arb_state_e;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  localparam int SEQ_DATA_W = 32;
  localparam logic [3:0] REG0 = 4'h0;
  localparam logic [3:0] REG1 = 4'h4;
  localparam logic [3:0] REG2 = 4'h8;
  localparam logic [3:0] REG3 = 4'hC;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sequencer_rr_arb.sv
// sequencer_rr_arb: combinational round-robin pick, scanning upward from the requester after last_i.
module sequencer_rr_arb
  import sequencer_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IW = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      last_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IW-1:0]      idx_o,
  output logic               any_o
);
  always_comb begin
    int j;
    grant_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(last_i) + k) % NUM_REQ;
      if (!any_o && req_i[j]) begin
        any_o = 1'b1;
        grant_o[j] = 1'b1;
        idx_o = IW'(j);
      end
    end
  end
endmodule

// File: rtl/sequencer_axil_arbiter.sv
// sequencer_axil_arbiter: round-robin share of one AXI4-Lite master port between NUM_REQ requesters,
// one transaction in flight, one-cycle completion pulse back to the owner.
module sequencer_axil_arbiter
  import sequencer_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = SEQ_DATA_W
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic [ADDR_W-1:0]         m_axi_awaddr,
  output logic [2:0]                m_axi_awprot,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [DATA_W-1:0]         m_axi_wdata,
  output logic [DATA_W/8-1:0]       m_axi_wstrb,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [ADDR_W-1:0]         m_axi_araddr,
  output logic [2:0]                m_axi_arprot,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [DATA_W-1:0]         m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
);
  localparam int IW = idx_w(NUM_REQ);
  seq_arb_state_e state_q, state_d;
  logic [IW-1:0] last_q, last_d, owner_q, owner_d, g_idx;
  logic [NUM_REQ-1:0] g_vec;
  logic g_any;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0] resp_q, resp_d;
  logic awv_q, awv_d, wv_q, wv_d, arv_q, arv_d;

  sequencer_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i(req_valid), .last_i(last_q), .grant_o(g_vec), .idx_o(g_idx), .any_o(g_any)
  );

  assign req_ready = (state_q == IDLE) ? g_vec : '0;
  assign rsp_valid = (state_q == RESP) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q) : '0;
  assign rsp_rdata = rdata_q;
  assign rsp_resp = resp_q;
  assign m_axi_awaddr = addr_q;
  assign m_axi_awprot = 3'b000;
  assign m_axi_awvalid = awv_q;
  assign m_axi_wdata = wdata_q;
  assign m_axi_wstrb = '1;
  assign m_axi_wvalid = wv_q;
  assign m_axi_bready = state_q == WR_B;
  assign m_axi_araddr = addr_q;
  assign m_axi_arprot = 3'b000;
  assign m_axi_arvalid = arv_q;
  assign m_axi_rready = state_q == RD_R;

  // AW and W retire independently; B is only awaited once both have handshaken
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    owner_d = owner_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    resp_d = resp_q;
    awv_d = awv_q;
    wv_d = wv_q;
    arv_d = arv_q;
    case (state_q)
      IDLE: if (g_any) begin
        last_d = g_idx;
        owner_d = g_idx;
        addr_d = req_addr[int'(g_idx)*ADDR_W +: ADDR_W];
        wdata_d = req_wdata[int'(g_idx)*DATA_W +: DATA_W];
        awv_d = req_we[g_idx];
        wv_d = req_we[g_idx];
        arv_d = !req_we[g_idx];
        state_d = req_we[g_idx] ? WR : RD_AR;
      end
      WR: begin
        awv_d = awv_q && !m_axi_awready;
        wv_d = wv_q && !m_axi_wready;
        state_d = (!awv_d && !wv_d) ? WR_B : WR;
      end
      WR_B: if (m_axi_bvalid) begin
        rdata_d = '0;
        resp_d = m_axi_bresp;
        state_d = RESP;
      end
      RD_AR: begin
        arv_d = arv_q && !m_axi_arready;
        state_d = arv_d ? RD_AR : RD_R;
      end
      RD_R: if (m_axi_rvalid) begin
        rdata_d = m_axi_rdata;
        resp_d = m_axi_rresp;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= IDLE;
      last_q <= IW'(NUM_REQ - 1);
      owner_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      resp_q <= AXI_RESP_OKAY;
      awv_q <= 1'b0;
      wv_q <= 1'b0;
      arv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      owner_q <= owner_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      resp_q <= resp_d;
      awv_q <= awv_d;
      wv_q <= wv_d;
      arv_q <= arv_d;
    end
  end
endmodule

// File: tb/tb_sequencer_axil_arbiter.sv
// tb_sequencer_axil_arbiter: directed and randomized checks of the arbiter against a register-slave model
// and a round-robin/memory reference model.
module tb_sequencer_axil_arbiter;
  localparam int N = 2, AW = 4, DW = 32;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready, req_we = '0, rsp_valid;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [DW-1:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0] m_axi_awprot, m_axi_arprot;
  logic m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_bvalid, m_axi_bready;
  logic m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
  logic [DW-1:0] m_axi_wdata, m_axi_rdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic [1:0] m_axi_bresp, m_axi_rresp;
  int total = 0, bad = 0;
  int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
  bit err_en = 1'b0;
  logic [31:0] exp_mem [4];
  int last_g = N - 1;

  always #5 clk = ~clk;

  sequencer_axil_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .ACLK(clk), .ARESET(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  // Register slave with programmable per-channel wait states
  int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic aw_got, w_got, ar_got;
  logic [3:0] aw_a, ar_a, wr_a, rd_a;
  logic [31:0] w_d, wr_d;
  logic [31:0] mem [4];
  logic aw_hs, w_hs, ar_hs;
  assign m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_wait);
  assign m_axi_wready = m_axi_wvalid && (w_cnt >= w_wait);
  assign m_axi_arready = m_axi_arvalid && (ar_cnt >= ar_wait);
  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs = m_axi_wvalid && m_axi_wready;
  assign ar_hs = m_axi_arvalid && m_axi_arready;
  assign wr_a = aw_hs ? m_axi_awaddr : aw_a;
  assign wr_d = w_hs ? m_axi_wdata : w_d;
  assign rd_a = ar_hs ? m_axi_araddr : ar_a;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      aw_got <= 0; w_got <= 0; ar_got <= 0; aw_a <= 0; ar_a <= 0; w_d <= 0;
      m_axi_bvalid <= 0; m_axi_rvalid <= 0; m_axi_bresp <= 0; m_axi_rresp <= 0; m_axi_rdata <= 0;
      for (int i = 0; i < 4; i++) mem[i] <= 0;
    end else begin
      if (m_axi_awvalid && !m_axi_awready) aw_cnt <= aw_cnt + 1;
      if (m_axi_wvalid && !m_axi_wready) w_cnt <= w_cnt + 1;
      if (m_axi_arvalid && !m_axi_arready) ar_cnt <= ar_cnt + 1;
      if (aw_hs) begin aw_cnt <= 0; aw_got <= 1; aw_a <= m_axi_awaddr; end
      if (w_hs) begin w_cnt <= 0; w_got <= 1; w_d <= m_axi_wdata; end
      if (ar_hs) begin ar_cnt <= 0; ar_got <= 1; ar_a <= m_axi_araddr; end
      if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 0;
      else if (!m_axi_bvalid && (aw_got || aw_hs) && (w_got || w_hs)) begin
        if (b_cnt >= b_wait) begin
          m_axi_bvalid <= 1; m_axi_bresp <= 2'b00; b_cnt <= 0; aw_got <= 0; w_got <= 0;
          mem[wr_a[3:2]] <= wr_d;
        end else b_cnt <= b_cnt + 1;
      end
      if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 0;
      else if (!m_axi_rvalid && (ar_got || ar_hs)) begin
        if (r_cnt >= r_wait) begin
          m_axi_rvalid <= 1; m_axi_rdata <= mem[rd_a[3:2]]; r_cnt <= 0; ar_got <= 0;
          m_axi_rresp <= (err_en && rd_a == 4'hC) ? 2'b10 : 2'b00;
        end else r_cnt <= r_cnt + 1;
      end
    end
  end

  // Handshake-stability monitor: a pending valid must stay high with unchanged payload
  logic p_aw = 0, p_w = 0, p_ar = 0;
  logic [3:0] p_awa, p_ara;
  logic [31:0] p_wd;
  always @(negedge clk) begin
    if (!rst) begin
      if (p_aw) begin
        total++;
        if (!m_axi_awvalid || m_axi_awaddr !== p_awa) begin bad++; $display("FAIL aw_hold: awvalid=%b awaddr=%h need 1/%h", m_axi_awvalid, m_axi_awaddr, p_awa); end
      end
      if (p_w) begin
        total++;
        if (!m_axi_wvalid || m_axi_wdata !== p_wd) begin bad++; $display("FAIL w_hold: wvalid=%b wdata=%h need 1/%h", m_axi_wvalid, m_axi_wdata, p_wd); end
      end
      if (p_ar) begin
        total++;
        if (!m_axi_arvalid || m_axi_araddr !== p_ara) begin bad++; $display("FAIL ar_hold: arvalid=%b araddr=%h need 1/%h", m_axi_arvalid, m_axi_araddr, p_ara); end
      end
      if (rsp_valid !== '0) begin
        total++;
        if (!$onehot(rsp_valid)) begin bad++; $display("FAIL rsp_onehot: rsp_valid=%b", rsp_valid); end
      end
    end
    p_aw = !rst && m_axi_awvalid && !m_axi_awready; p_awa = m_axi_awaddr;
    p_w = !rst && m_axi_wvalid && !m_axi_wready; p_wd = m_axi_wdata;
    p_ar = !rst && m_axi_arvalid && !m_axi_arready; p_ara = m_axi_araddr;
  end

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] r;
    r = '0;
    if (i >= 0) r[i] = 1'b1;
    return r;
  endfunction

  // Present a command and hold it until accepted; returns at the negedge after the accept edge
  task automatic issue(input int r, input bit we, input logic [3:0] a, input logic [31:0] d);
    bit ok;
    @(negedge clk);
    req_we[r] = we; req_addr[r*AW +: AW] = a; req_wdata[r*DW +: DW] = d; req_valid[r] = 1'b1;
    ok = 0;
    for (int c = 0; c < 40 && !ok; c++) begin #1; ok = req_ready[r]; @(negedge clk); end
    req_valid[r] = 1'b0;
    if (ok) last_g = r;
    total++;
    if (!ok) begin bad++; $display("FAIL accept r%0d: req_ready never seen", r); end
  endtask

  // Latency counts cycles after the accept cycle until rsp_valid
  task automatic wait_rsp(output logic [31:0] rd, output logic [1:0] rs, output int lat,
                          output logic [N-1:0] rv, output logic [N-1:0] extra);
    lat = 1;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (rsp_valid !== '0) break;
      @(negedge clk);
      lat++;
    end
    rv = rsp_valid; rd = rsp_rdata; rs = rsp_resp;
    @(negedge clk); #1;
    extra = rsp_valid;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    total++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready} !== 5'b0 ||
        req_ready !== '0 || rsp_valid !== '0) begin
      bad++; $display("FAIL reset_ctrl: aw/w/ar/b/r=%b%b%b%b%b ready=%b rsp=%b need all 0",
        m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, req_ready, rsp_valid);
    end
    total++;
    if (rsp_rdata !== 32'h0 || rsp_resp !== 2'b00) begin bad++; $display("FAIL reset_data: rdata=%h resp=%b need 0/00", rsp_rdata, rsp_resp); end
    @(negedge clk); rst = 1'b0; #1;
    total++;
    if (req_ready !== '0) begin bad++; $display("FAIL idle_ready: req_ready=%b need 00", req_ready); end
    req_we = '0; req_valid = '1; #1;
    total++;
    if (req_ready !== oh(0)) begin bad++; $display("FAIL reset_prio: req_ready=%b need %b", req_ready, oh(0)); end
    req_valid = '0;
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic [1:0] rs; int lat; logic [N-1:0] rv, ex;
    for (int i = 0; i < 4; i++) begin
      issue(0, 1, 4'(i * 4), 32'(i + 1));
      wait_rsp(rd, rs, lat, rv, ex);
      exp_mem[i] = 32'(i + 1);
      total++;
      if (rv !== oh(0) || ex !== '0 || lat != 3) begin bad++; $display("FAIL wr%0d_pulse: rsp=%b next=%b lat=%0d need %b/00/3", i, rv, ex, lat, oh(0)); end
      total++;
      if (rd !== 32'h0 || rs !== 2'b00) begin bad++; $display("FAIL wr%0d_rsp: rdata=%h resp=%b need 0/00", i, rd, rs); end
    end
    for (int i = 0; i < 4; i++) begin
      issue(0, 0, 4'(i * 4), 32'h0);
      wait_rsp(rd, rs, lat, rv, ex);
      total++;
      if (rv !== oh(0) || ex !== '0 || lat != 3) begin bad++; $display("FAIL rd%0d_pulse: rsp=%b next=%b lat=%0d need %b/00/3", i, rv, ex, lat, oh(0)); end
      total++;
      if (rd !== exp_mem[i] || rs !== 2'b00) begin bad++; $display("FAIL rd%0d_rsp: rdata=%h resp=%b need %h/00", i, rd, rs, exp_mem[i]); end
    end
  endtask

  task automatic test_alternate();
    int gq[$], rq[$];
    int e;
    @(negedge clk);
    req_we = '1; req_addr = {4'h4, 4'h0}; req_wdata = {32'h22, 32'h11}; req_valid = '1;
    for (int c = 0; c < 40; c++) begin
      #1;
      for (int r = 0; r < N; r++) begin
        if (req_ready[r]) gq.push_back(r);
        if (rsp_valid[r]) rq.push_back(r);
      end
      @(negedge clk);
      if (gq.size() >= 6) req_valid = '0;
    end
    total++;
    if (gq.size() != 6 || rq.size() != 6) begin bad++; $display("FAIL alt_count: grants=%0d rsps=%0d need 6/6", gq.size(), rq.size()); end
    e = last_g;
    for (int k = 0; k < gq.size() && k < rq.size(); k++) begin
      e = rr_pick('1, e);
      total++;
      if (gq[k] != e || rq[k] != e) begin bad++; $display("FAIL alt_%0d: grant=%0d rsp=%0d need %0d", k, gq[k], rq[k], e); end
    end
    last_g = e;
    exp_mem[0] = 32'h11; exp_mem[1] = 32'h22;
  endtask

  task automatic test_aw_stall();
    logic [2:0] e [5] = '{3'b110, 3'b100, 3'b100, 3'b100, 3'b001};
    logic [31:0] rd; logic [1:0] rs; int lat; logic [N-1:0] rv, ex;
    aw_wait = 3;
    issue(0, 1, 4'h8, 32'h55);
    for (int k = 0; k < 5; k++) begin
      #1;
      total++;
      if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== e[k] || (m_axi_awvalid && m_axi_awaddr !== 4'h8)) begin
        bad++; $display("FAIL stall_c%0d: aw/w/b=%b awaddr=%h need %b/8", k + 1, {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, m_axi_awaddr, e[k]);
      end
      @(negedge clk);
    end
    wait_rsp(rd, rs, lat, rv, ex);
    total++;
    if (rv !== oh(0) || rs !== 2'b00 || lat != 1) begin bad++; $display("FAIL stall_rsp: rsp=%b resp=%b lat=%0d need %b/00/1", rv, rs, lat, oh(0)); end
    aw_wait = 0;
    exp_mem[2] = 32'h55;
  endtask

  task automatic test_slverr();
    logic [31:0] rd; logic [1:0] rs; int lat; logic [N-1:0] rv, ex;
    err_en = 1;
    issue(1, 0, 4'hC, 32'h0);
    wait_rsp(rd, rs, lat, rv, ex);
    total++;
    if (rv !== oh(1) || rs !== 2'b10 || rd !== exp_mem[3]) begin bad++; $display("FAIL slverr: rsp=%b resp=%b rdata=%h need %b/10/%h", rv, rs, rd, oh(1), exp_mem[3]); end
    issue(0, 0, 4'h0, 32'h0);
    wait_rsp(rd, rs, lat, rv, ex);
    total++;
    if (rv !== oh(0) || rs !== 2'b00 || rd !== exp_mem[0] || lat != 3) begin bad++; $display("FAIL after_err: rsp=%b resp=%b rdata=%h lat=%0d need %b/00/%h/3", rv, rs, rd, lat, oh(0), exp_mem[0]); end
    err_en = 0;
  endtask

  task automatic test_drop();
    logic s0, s1;
    s0 = 0; s1 = 0;
    issue(0, 1, 4'h4, 32'h77);
    req_we[1] = 1'b0; req_addr[AW +: AW] = 4'h0; req_valid[1] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      s1 |= req_ready[1] | rsp_valid[1];
      s0 |= rsp_valid[0];
      @(negedge clk);
      if (c == 0) req_valid[1] = 1'b0;
    end
    exp_mem[1] = 32'h77;
    total++;
    if (s1 !== 1'b0) begin bad++; $display("FAIL drop_r1: req1 granted/responded=%b need 0", s1); end
    total++;
    if (s0 !== 1'b1) begin bad++; $display("FAIL drop_r0: req0 response seen=%b need 1", s0); end
  endtask

  task automatic test_reset_mid();
    logic s;
    b_wait = 5;
    issue(1, 1, 4'h4, 32'h99);
    @(negedge clk); #1;
    total++;
    if (m_axi_bready !== 1'b1) begin bad++; $display("FAIL midrst_wrb: bready=%b need 1", m_axi_bready); end
    rst = 1'b1; #1;
    total++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready} !== 5'b0 || rsp_valid !== '0) begin
      bad++; $display("FAIL midrst_async: aw/w/ar/b/r=%b%b%b%b%b rsp=%b need 0",
        m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid);
    end
    s = 0;
    repeat (2) begin @(negedge clk); #1; s |= |rsp_valid; end
    rst = 1'b0;
    b_wait = 0;
    last_g = N - 1;
    for (int i = 0; i < 4; i++) exp_mem[i] = 0;
    repeat (3) begin @(negedge clk); #1; s |= |rsp_valid; end
    total++;
    if (s !== 1'b0) begin bad++; $display("FAIL midrst_rsp: rsp_valid seen=%b need 0", s); end
    req_we = '0; req_valid = '1; #1;
    total++;
    if (req_ready !== oh(0)) begin bad++; $display("FAIL midrst_prio: req_ready=%b need %b", req_ready, oh(0)); end
    req_valid = '0;
  endtask

  task automatic test_random();
    int busy, bc, own, done, g;
    logic [31:0] exp_rd; logic [1:0] exp_rs;
    logic [N-1:0] acc, er;
    logic [3:0] a;
    busy = 0; bc = 0; own = 0; done = 0; acc = '0; exp_rd = 0; exp_rs = 0;
    err_en = 1;
    for (int cyc = 0; cyc < 4000 && done < 120; cyc++) begin
      @(negedge clk);
      for (int r = 0; r < N; r++) begin
        if (acc[r]) req_valid[r] = 1'b0;
        else if (req_valid[r] && $urandom_range(0, 15) == 0) req_valid[r] = 1'b0;
        if (!req_valid[r] && $urandom_range(0, 2) == 0) begin
          req_we[r] = 1'($urandom_range(0, 1));
          req_addr[r*AW +: AW] = {2'($urandom_range(0, 3)), 2'b00};
          req_wdata[r*DW +: DW] = $urandom;
          req_valid[r] = 1'b1;
        end
      end
      acc = '0;
      #1;
      if (rsp_valid !== '0) begin
        total++;
        if (!busy || rsp_valid !== oh(own)) begin bad++; $display("FAIL rnd_owner: rsp=%b need %b busy=%0d", rsp_valid, oh(own), busy); end
        total++;
        if (rsp_rdata !== exp_rd || rsp_resp !== exp_rs) begin bad++; $display("FAIL rnd_data: rdata=%h resp=%b need %h/%b", rsp_rdata, rsp_resp, exp_rd, exp_rs); end
        total++;
        if (req_ready !== '0) begin bad++; $display("FAIL rnd_resp_ready: req_ready=%b need 0", req_ready); end
        busy = 0; done++;
      end else begin
        g = busy ? -1 : rr_pick(req_valid, last_g);
        er = oh(g);
        total++;
        if (req_ready !== er) begin bad++; $display("FAIL rnd_grant: req_ready=%b need %b", req_ready, er); end
        if (g >= 0) begin
          busy = 1; bc = 0; own = g; last_g = g; acc[g] = 1'b1;
          a = req_addr[g*AW +: AW];
          if (req_we[g]) begin
            exp_mem[a[3:2]] = req_wdata[g*DW +: DW]; exp_rd = 0; exp_rs = 2'b00;
          end else begin
            exp_rd = exp_mem[a[3:2]]; exp_rs = (a == 4'hC) ? 2'b10 : 2'b00;
          end
          aw_wait = $urandom_range(0, 3); w_wait = $urandom_range(0, 3); b_wait = $urandom_range(0, 2);
          ar_wait = $urandom_range(0, 3); r_wait = $urandom_range(0, 2);
        end else if (busy && ++bc > 60) begin
          bad++; $display("FAIL rnd_timeout: no response for owner %0d", own); busy = 0;
        end
      end
    end
    req_valid = '0;
    repeat (12) @(negedge clk);
    err_en = 0;
    total++;
    if (done < 120) begin bad++; $display("FAIL rnd_progress: completions=%0d need 120", done); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) exp_mem[i] = 0;
    test_reset();
    test_write_read();
    test_alternate();
    test_aw_stall();
    test_slverr();
    test_drop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
